// File: rtl/ifetch_if.sv
// Fetch-stage bundle: pc-side address/stall, instruction-memory req/ack bus,
// and the valid/ready output toward decode.
interface ifetch_if;
    logic [31:0] fetch_addr;
    logic        flush;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        dec_ready;
    logic        fetch_fault;

    modport master (
        input  fetch_addr, flush, imem_ack, imem_rdata, dec_ready,
        output pc_stall, imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_fault
    );

    modport slave (
        output fetch_addr, flush, imem_ack, imem_rdata, dec_ready,
        input  pc_stall, imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_fault
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: single-outstanding imem request, one-entry skid, valid/ready to decode.
// IFETCH_ALIGN_CHECK_EN: misaligned fetch addresses produce a fault word instead of a request.
module ifetch #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rest,
    ifetch_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fault_q, fault_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        capture, pc_adv, out_free, transfer;

    always_comb begin
        state_d       = state_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        capture       = 1'b0;
        pc_adv        = 1'b0;
        out_free      = !instr_valid_q || bus.dec_ready;
        transfer      = instr_valid_q && bus.dec_ready;

        case (state_q)
            S_IDLE: begin
                if (!bus.flush) begin
`ifdef IFETCH_ALIGN_CHECK_EN
                    if (bus.fetch_addr[1:0] != 2'b00) begin
                        // Misaligned PC becomes a faulting nop; pc advances only once it lands.
                        if (out_free) begin
                            instr_d    = RESET_INSTR;
                            instr_pc_d = bus.fetch_addr;
                            fault_d    = 1'b1;
                            capture    = 1'b1;
                            pc_adv     = 1'b1;
                        end
                    end else
`endif
                    begin
                        imem_req_d  = 1'b1;
                        imem_addr_d = {bus.fetch_addr[31:2], 2'b00};
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                pc_adv = bus.imem_ack;
                if (bus.imem_ack && bus.flush) begin
                    imem_req_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (bus.flush) begin
                    // Request stays up: the memory still owes us an ack we must swallow.
                    state_d = S_DROP;
                end else if (bus.imem_ack && out_free) begin
                    instr_d    = bus.imem_rdata;
                    instr_pc_d = imem_addr_q;
                    fault_d    = 1'b0;
                    capture    = 1'b1;
                    imem_req_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (bus.imem_ack) begin
                    skid_instr_d = bus.imem_rdata;
                    skid_pc_d    = imem_addr_q;
                    imem_req_d   = 1'b0;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (bus.dec_ready) begin
                    instr_d    = skid_instr_q;
                    instr_pc_d = skid_pc_q;
                    fault_d    = 1'b0;
                    capture    = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_DROP: begin
                if (bus.imem_ack) begin
                    imem_req_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.flush) begin
            instr_valid_d = 1'b0;
            instr_d       = RESET_INSTR;
            fault_d       = 1'b0;
        end else if (capture) begin
            instr_valid_d = 1'b1;
        end else if (transfer) begin
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q       <= S_IDLE;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= 32'h0;
            instr_q       <= RESET_INSTR;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            skid_instr_q  <= 32'h0;
            skid_pc_q     <= 32'h0;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
        end
    end

    assign bus.pc_stall    = !(bus.flush || pc_adv);
    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.fetch_fault = fault_q;
endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage between `pc` and decode. Takes the current fetch address from `pc`, issues a single-outstanding request/acknowledge transaction to instruction memory, and registers the returned word with its address. Presents the result to decode over a valid/ready handshake. Holds `pc` through `pc_stall` until the fetch for the current address is accepted, and discards wrong-path data on `flush`.

## Interface
- `RESET_INSTR`, default 32'h00000000: value driven on `instr` after reset, flush and fault (MIPS nop).
- `clk` in 1: clock, all state on rising edge.
- `rest` in 1: asynchronous, active-low reset.
- `fetch_addr` in 32: current PC, from `pc` `addr`.
- `flush` in 1: redirect/kill from downstream; discards all fetched and in-flight data.
- `imem_req` out 1: memory request, registered.
- `imem_addr` out 32: request address, registered, stable while `imem_req`=1.
- `imem_ack` in 1: one-cycle response strobe, valid only while `imem_req`=1.
- `imem_rdata` in 32: instruction word, sampled when `imem_ack`=1.
- `instr` out 32: fetched instruction, registered.
- `instr_pc` out 32: address of `instr`, registered.
- `instr_valid` out 1: `instr`/`instr_pc` valid.
- `dec_ready` in 1: decode accepts; a transfer occurs when `instr_valid`&&`dec_ready`.
- `pc_stall` out 1: combinational; 1 holds `pc`.
- `fetch_fault` out 1: registered; misaligned fetch, qualified by `instr_valid`.

## Operation
- `out_free` = !`instr_valid` || `dec_ready`.
- States: S_IDLE, S_REQ, S_HOLD, S_DROP. One skid register, `skid_instr`/`skid_pc`.
- **S_IDLE:** if !`flush`, set `imem_req`<=1 and `imem_addr`<=`fetch_addr`, then go to S_REQ.
- **S_REQ:**
  - `imem_ack` && `flush`: drop the data, `imem_req`<=0, go to S_IDLE.
  - !`imem_ack` && `flush`: go to S_DROP with `imem_req` kept at 1.
  - `imem_ack` && `out_free`: `instr`<=`imem_rdata`, `instr_pc`<=`imem_addr`, `instr_valid`<=1, `imem_req`<=0, go to S_IDLE.
  - `imem_ack` && !`out_free`: skid<=data/addr, `imem_req`<=0, go to S_HOLD.
- **S_HOLD:**
  - `flush`: drop the skid, go to S_IDLE.
  - `dec_ready`: output regs<=skid, `instr_valid`<=1, go to S_IDLE.
- **S_DROP:** `imem_req` stays at 1 until `imem_ack`. On `imem_ack`, `imem_req`<=0 and go to S_IDLE. `flush` has no further effect here.
- `pc_stall` = 0 when `flush`=1, or when in S_REQ with `imem_ack`=1. Otherwise `pc_stall` = 1. `pc` therefore advances exactly once per accepted fetch.
- `instr_valid` next value, in priority order:
  - `flush`: 0.
  - capture from memory or skid: 1.
  - transfer with no capture: 0.
  - otherwise: hold.
- `flush` forces `instr`<=`RESET_INSTR` and `fetch_fault`<=0.
- Never more than one outstanding request. `imem_addr` never changes while `imem_req`=1.

## Timing
- Reset (`rest`=0, asynchronous) puts the block in S_IDLE with:
  - `imem_req`=0, `imem_addr`=0.
  - `instr`=`RESET_INSTR`, `instr_pc`=0.
  - `instr_valid`=0, `fetch_fault`=0, skid=0.
- First `imem_req` rises on the 1st edge after `rest` deasserts.
- With `imem_ack` arriving N cycles after `imem_req` rises (N≥1), `instr_valid` rises 1 edge after the ack.
- Peak throughput is 1 instruction per 2 cycles (N=1); each completion costs one S_IDLE bubble.
- Reset mid-transaction: all state is cleared immediately. The memory must tolerate an abandoned request.
- When flush and capture coincide, flush wins. When flush and transfer coincide, the transfer still counts for decode.

## Configuration
- Macro `IFETCH_ALIGN_CHECK_EN`.
- **Defined:** in S_IDLE with `fetch_addr[1:0]`≠0 and !`flush`, no request is issued.
  - If `out_free`: `instr`<=`RESET_INSTR`, `instr_pc`<=`fetch_addr`, `fetch_fault`<=1, `instr_valid`<=1.
  - `pc_stall`=0 in that cycle; otherwise stay in S_IDLE with `pc_stall`=1.
  - `fetch_fault` clears on the next capture or on `flush`.
- **Undefined:** `fetch_fault` is tied to 0, and `imem_addr[1:0]` is forced to 2'b00.

## Test plan
- **Reset:** `rest`=0 mid-S_REQ → all outputs at reset values within the same cycle; after release, `imem_req`=1 and `imem_addr`=32'h80000200 one edge later.
- **Single fetch, N=1:** `fetch_addr`=32'h80000200, ack with rdata 32'h24080005, `dec_ready`=1 → `pc_stall`=0 in the ack cycle. Next edge: `instr`=32'h24080005, `instr_pc`=32'h80000200, `instr_valid`=1.
- **Latency N=3:** `pc_stall`=1 for 2 cycles and `imem_addr` stable throughout; `instr_valid` rises after the ack.
- **Backpressure:** `dec_ready`=0 with an instruction held, ack arrives → skid filled, state S_HOLD, `imem_req`=0. Raising `dec_ready` → skid word appears on `instr` the next edge, with no word lost or duplicated.
- **Flush in flight:** `flush` 1 cycle after `imem_req` rises, ack 2 cycles later with 32'hDEADBEEF → 32'hDEADBEEF never appears on `instr`; a new request with the redirected `fetch_addr` follows S_DROP.
- **Misaligned (macro on):** `fetch_addr`=32'h80000202 → no `imem_req`; `instr_valid`=1, `fetch_fault`=1, `instr`=`RESET_INSTR`.
